// File: rtl/prienc_pkg.sv
// Shared types and helpers for the registered N-input priority/round-robin arbiter.
package prienc_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Descending pointer step with wrap from 0 back to n-1.
  function automatic int ptr_dec(input int idx, input int n);
    return (idx == 0) ? n - 1 : idx - 1;
  endfunction

endpackage

// File: rtl/prienc_rot_n.sv
// Combinational rotating priority encoder: searches req downward from
// index 'start', wrapping from 0 to N-1; the first set bit wins.
module prienc_rot_n #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [IW-1:0] idx,
  output logic          any
);

  // One extra bit lets start+N-off address a doubled copy of req without modulo.
  localparam int PW = IW + 1;

  logic [2*N-1:0] req2;
  logic [PW-1:0]  pos;

  assign req2 = {req, req};

  // Walk offsets from farthest to nearest so the nearest set bit is the final winner.
  always_comb begin
    idx = '0;
    any = 1'b0;
    pos = '0;
    for (int off = N - 1; off >= 0; off--) begin
      pos = PW'(start) + PW'(N) - PW'(off);
      if (req2[pos]) begin
        any = 1'b1;
        idx = (pos >= PW'(N)) ? IW'(pos - PW'(N)) : IW'(pos);
      end
    end
  end

endmodule

// File: rtl/prienc_rr_arbiter.sv
// Registered N-way arbiter with run-time selectable fixed (MSB highest) or
// round-robin priority, grant held until release or optional hold timeout.
//
// Handshake: a requester raises req[k] and keeps it high for as long as it
// wants ownership; gnt[k]/gnt_vld appear one cycle after req[k] is sampled in
// IDLE and stay stable until req[k] is sampled low (or the hold timeout fires,
// signalled by a one-cycle tmo_evt). At least one idle cycle separates grants.
module prienc_rr_arbiter
  import prienc_pkg::*;
#(
  parameter int N   = 4,
  parameter int TMO = 0,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mode,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_vld,
  output logic          tmo_evt,
  output state_e        dbg_state,
  output logic [IW-1:0] dbg_ptr
);

  localparam bit          TMO_EN   = (TMO > 0);
  localparam logic [15:0] TMO_LAST = 16'((TMO > 0) ? TMO - 1 : 0);
  localparam logic [IW-1:0] TOP_IDX = IW'(N - 1);

  state_e        state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] gnt_idx_q, gnt_idx_d;
  logic          gnt_vld_q, gnt_vld_d;
  logic          tmo_evt_q, tmo_evt_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [15:0]   cnt_q, cnt_d;

  logic [IW-1:0] start;
  logic [IW-1:0] win_idx;
  logic          win_any;

  // Fixed mode is round-robin with the search pinned at the top index.
  assign start = (mode == MODE_RR) ? ptr_q : TOP_IDX;

  prienc_rot_n #(.N(N), .IW(IW)) u_rot (
    .req   (req),
    .start (start),
    .idx   (win_idx),
    .any   (win_any)
  );

  // Next-state: arbitrate in IDLE; in GRANT hold, count, and release.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_idx_d = gnt_idx_q;
    gnt_vld_d = gnt_vld_q;
    tmo_evt_d = 1'b0;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (win_any) begin
          state_d        = GRANT;
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          gnt_idx_d      = win_idx;
          gnt_vld_d      = 1'b1;
          cnt_d          = '0;
        end
      end
      GRANT: begin
        if (!req[gnt_idx_q] || (TMO_EN && (cnt_q == TMO_LAST))) begin
          // A dropping request wins over a coincident timeout: no event then.
          tmo_evt_d = req[gnt_idx_q];
          state_d   = IDLE;
          gnt_d     = '0;
          gnt_idx_d = '0;
          gnt_vld_d = 1'b0;
          ptr_d     = IW'(ptr_dec(int'(gnt_idx_q), N));
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset overrides every other event.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gnt_idx_q <= '0;
      gnt_vld_q <= 1'b0;
      tmo_evt_q <= 1'b0;
      ptr_q     <= TOP_IDX;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_idx_q <= gnt_idx_d;
      gnt_vld_q <= gnt_vld_d;
      tmo_evt_q <= tmo_evt_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_vld   = gnt_vld_q;
  assign tmo_evt   = tmo_evt_q;
  assign dbg_state = state_q;
  assign dbg_ptr   = ptr_q;

endmodule

// File: tb/tb_prienc_rr_arbiter.sv
// Directed bench for prienc_rr_arbiter (N=4): one instance without timeout,
// one with TMO=5, both driven by the same inputs.
module tb_prienc_rr_arbiter;
  import prienc_pkg::*;

  logic       clk;
  logic       rst;
  logic       mode;
  logic [3:0] req;

  logic [3:0] gnt0, gnt5;
  logic [1:0] idx0, idx5;
  logic       vld0, vld5;
  logic       tmo0, tmo5;
  state_e     st0, st5;
  logic [1:0] ptr0, ptr5;

  int checks = 0;
  int errors = 0;

  prienc_rr_arbiter #(.N(4), .TMO(0)) u_dut0 (
    .clk(clk), .rst(rst), .mode(mode), .req(req),
    .gnt(gnt0), .gnt_idx(idx0), .gnt_vld(vld0), .tmo_evt(tmo0),
    .dbg_state(st0), .dbg_ptr(ptr0)
  );

  prienc_rr_arbiter #(.N(4), .TMO(5)) u_dut5 (
    .clk(clk), .rst(rst), .mode(mode), .req(req),
    .gnt(gnt5), .gnt_idx(idx5), .gnt_vld(vld5), .tmo_evt(tmo5),
    .dbg_state(st5), .dbg_ptr(ptr5)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs change and outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    mode = MODE_FIXED;
    req  = 4'b1111;
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if (gnt0 !== 4'b0000 || idx0 !== 2'd0 || vld0 !== 1'b0 || tmo0 !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: gnt=%b idx=%0d vld=%b tmo=%b, want 0000/0/0/0",
                 c, gnt0, idx0, vld0, tmo0);
      end
      checks++;
      if (st0 !== IDLE || ptr0 !== 2'd3) begin
        errors++;
        $display("FAIL reset_state cycle %0d: state=%0d ptr=%0d, want IDLE/3", c, st0, ptr0);
      end
    end
    rst = 1'b0;
    step();
    checks++;
    if (gnt0 !== 4'b1000 || idx0 !== 2'd3 || vld0 !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_grant: gnt=%b idx=%0d vld=%b, want 1000/3/1", gnt0, idx0, vld0);
    end
  endtask

  task automatic test_fixed();
    do_reset();
    mode = MODE_FIXED;
    req  = 4'b0110;
    step();
    checks++;
    if (gnt0 !== 4'b0100 || idx0 !== 2'd2) begin
      errors++;
      $display("FAIL fixed_grant: gnt=%b idx=%0d, want 0100/2", gnt0, idx0);
    end
    req = 4'b1110;
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if (gnt0 !== 4'b0100 || vld0 !== 1'b1) begin
        errors++;
        $display("FAIL fixed_hold cycle %0d: gnt=%b vld=%b, want 0100/1", c, gnt0, vld0);
      end
    end
    req = 4'b1010;
    step();
    checks++;
    if (gnt0 !== 4'b0000 || vld0 !== 1'b0 || ptr0 !== 2'd1) begin
      errors++;
      $display("FAIL fixed_release: gnt=%b vld=%b ptr=%0d, want 0000/0/1", gnt0, vld0, ptr0);
    end
    step();
    checks++;
    if (gnt0 !== 4'b1000 || idx0 !== 2'd3) begin
      errors++;
      $display("FAIL fixed_regrant: gnt=%b idx=%0d, want 1000/3", gnt0, idx0);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_idx [5] = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3};
    logic [3:0] exp_gnt;
    do_reset();
    mode = MODE_RR;
    req  = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      exp_gnt = 4'b0001 << exp_idx[k];
      checks++;
      if (gnt0 !== exp_gnt || idx0 !== exp_idx[k]) begin
        errors++;
        $display("FAIL rr_order[%0d]: gnt=%b idx=%0d, want %b/%0d", k, gnt0, idx0, exp_gnt, exp_idx[k]);
      end
      if (k < 4) begin
        req = 4'b1111 & ~exp_gnt;
        step();
        checks++;
        if (vld0 !== 1'b0 || gnt0 !== 4'b0000) begin
          errors++;
          $display("FAIL rr_release[%0d]: gnt=%b vld=%b, want 0000/0", k, gnt0, vld0);
        end
        req = 4'b1111;
      end
    end
  endtask

  task automatic test_rr_wrap();
    do_reset();
    mode = MODE_RR;
    req  = 4'b0100;
    step();
    req = 4'b0000;
    step();
    checks++;
    if (ptr0 !== 2'd1) begin
      errors++;
      $display("FAIL wrap_setup_ptr: ptr=%0d, want 1", ptr0);
    end
    req = 4'b1010;
    step();
    checks++;
    if (gnt0 !== 4'b0010 || idx0 !== 2'd1) begin
      errors++;
      $display("FAIL wrap_first: gnt=%b idx=%0d, want 0010/1", gnt0, idx0);
    end
    req = 4'b1000;
    step();
    checks++;
    if (gnt0 !== 4'b0000 || ptr0 !== 2'd0) begin
      errors++;
      $display("FAIL wrap_release: gnt=%b ptr=%0d, want 0000/0", gnt0, ptr0);
    end
    req = 4'b1010;
    step();
    checks++;
    if (gnt0 !== 4'b1000 || idx0 !== 2'd3) begin
      errors++;
      $display("FAIL wrap_second: gnt=%b idx=%0d, want 1000/3", gnt0, idx0);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    mode = MODE_RR;
    req  = 4'b1001;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (vld5 !== 1'b1 || gnt5 !== 4'b1000 || tmo5 !== 1'b0) begin
        errors++;
        $display("FAIL tmo_hold cycle %0d: gnt=%b vld=%b tmo=%b, want 1000/1/0", c, gnt5, vld5, tmo5);
      end
    end
    step();
    checks++;
    if (vld5 !== 1'b0 || tmo5 !== 1'b1 || ptr5 !== 2'd2) begin
      errors++;
      $display("FAIL tmo_fire: vld=%b tmo=%b ptr=%0d, want 0/1/2", vld5, tmo5, ptr5);
    end
    step();
    checks++;
    if (gnt5 !== 4'b0001 || tmo5 !== 1'b0) begin
      errors++;
      $display("FAIL tmo_regrant: gnt=%b tmo=%b, want 0001/0", gnt5, tmo5);
    end
    checks++;
    if (gnt0 !== 4'b1000 || tmo0 !== 1'b0) begin
      errors++;
      $display("FAIL tmo_disabled: gnt=%b tmo=%b, want 1000/0", gnt0, tmo0);
    end
    for (int c = 0; c < 4; c++) step();
    req = 4'b1000;
    step();
    checks++;
    if (vld5 !== 1'b0 || tmo5 !== 1'b0 || ptr5 !== 2'd3) begin
      errors++;
      $display("FAIL tmo_coincident_drop: vld=%b tmo=%b ptr=%0d, want 0/0/3", vld5, tmo5, ptr5);
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    mode = MODE_RR;
    req  = 4'b0100;
    step();
    checks++;
    if (gnt0 !== 4'b0100) begin
      errors++;
      $display("FAIL midrst_setup: gnt=%b, want 0100", gnt0);
    end
    rst = 1'b1;
    req = 4'b0101;
    step();
    checks++;
    if (gnt0 !== 4'b0000 || vld0 !== 1'b0 || tmo0 !== 1'b0 || ptr0 !== 2'd3) begin
      errors++;
      $display("FAIL midrst_drop: gnt=%b vld=%b tmo=%b ptr=%0d, want 0000/0/0/3",
               gnt0, vld0, tmo0, ptr0);
    end
    rst = 1'b0;
    step();
    checks++;
    if (gnt0 !== 4'b0100 || idx0 !== 2'd2) begin
      errors++;
      $display("FAIL midrst_regrant: gnt=%b idx=%0d, want 0100/2", gnt0, idx0);
    end
  endtask

  initial begin
    rst  = 1'b1;
    mode = MODE_FIXED;
    req  = 4'b0000;
    test_reset();
    test_fixed();
    test_round_robin();
    test_rr_wrap();
    test_timeout();
    test_reset_mid_grant();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
